// File: rtl/demux_1_4_stream_if.sv
// ---------------------------------------------------------------------------
// demux_1_4_stream_if
//   Bundle of the handshake signals around the 1:4 stream demux.
//   Input side : in_valid, in_ready, in_data, in_sel
//   Output side: out_valid[3:0], out_ready[3:0], out_data (4 slices),
//                out_count (4 slices)
//   Modports:
//     slave  - the demux itself (consumes the input stream, drives outputs)
//     master - the environment (producer + four consumers)
// ---------------------------------------------------------------------------
interface demux_1_4_stream_if #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic [1:0]            in_sel;
    logic [3:0]            out_valid;
    logic [3:0]            out_ready;
    logic [4*DATA_W-1:0]   out_data;
    logic [4*CNT_W-1:0]    out_count;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_sel,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_count
    );

    modport master (
        output in_valid,
        output in_data,
        output in_sel,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_count
    );
endinterface

// File: rtl/demux_1_4_stream.sv
// ---------------------------------------------------------------------------
// demux_1_4_stream
//   Steers one valid/ready input stream to one of four output streams chosen
//   per beat by in_sel. Each output owns a DEPTH-entry FIFO so a stalled
//   consumer only blocks beats addressed to it.
//   Ports:
//     clk    - clock, rising edge
//     rst_n  - asynchronous reset, active-low
//     bus    - demux_1_4_stream_if.slave (input stream + four output streams
//              + per-output occupancy)
//   DEPTH must be a power of two and >= 2; pointers wrap naturally.
// ---------------------------------------------------------------------------
module demux_1_4_stream #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    demux_1_4_stream_if.slave      bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [3:0]        full;
    logic [3:0]        empty;
    logic [3:0]        push;
    logic [3:0]        pop;
    logic [DATA_W-1:0] head  [4];
    logic [CNT_W-1:0]  count [4];
    logic              accept;

    // A full FIFO can still take a beat when its consumer drains one in the
    // same cycle; in_valid deliberately plays no part here.
    assign bus.in_ready = !full[bus.in_sel] || bus.out_ready[bus.in_sel];
    assign accept       = bus.in_valid && bus.in_ready;

    for (genvar k = 0; k < 4; k++) begin : g_fifo
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  cnt;

        assign full[k]  = (cnt == FULL_CNT);
        assign empty[k] = (cnt == '0);
        assign push[k]  = accept && (bus.in_sel == 2'(k));
        assign pop[k]   = !empty[k] && bus.out_ready[k];

        // Storage is cleared on reset so out_data reads zero while held.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end else if (push[k]) begin
                mem[wr_ptr] <= bus.in_data;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push[k]) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop[k]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push[k], pop[k]})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end

        assign head[k]  = mem[rd_ptr];
        assign count[k] = cnt;
    end

    always_comb begin
        bus.out_valid = ~empty;
        bus.out_data  = '0;
        bus.out_count = '0;
        for (int k = 0; k < 4; k++) begin
            bus.out_data[k*DATA_W +: DATA_W] = head[k];
            bus.out_count[k*CNT_W +: CNT_W]  = count[k];
        end
    end
endmodule

// File: tb/tb_demux_1_4_stream.sv
module tb_demux_1_4_stream;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 2;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    demux_1_4_stream_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    demux_1_4_stream #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [3:0] route_val [4];

    initial begin
        total = 0;
        bad   = 0;
        route_val[0] = 4'hA;
        route_val[1] = 4'h5;
        route_val[2] = 4'h3;
        route_val[3] = 4'hC;

        // 1. reset
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = 2'd0;
        bus.out_ready = 4'b0000;
        #12;
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_count", 32'(bus.out_count), 32'h0);
        check("rst_data",  32'(bus.out_data),  32'h0);
        check("rst_ready", 32'(bus.in_ready),  32'h1);
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_valid", 32'(bus.out_valid), 32'h0);
        check("post_rst_count", 32'(bus.out_count), 32'h0);

        // 2. routing
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = 2'(i);
            bus.in_data  = route_val[i];
            settle();
            check("route_ready", 32'(bus.in_ready), 32'h1);
            if (i == 0) check("route_no_bypass", 32'(bus.out_valid), 32'h0);
            tick();
        end
        bus.in_valid = 1'b0;
        check("route_valid", 32'(bus.out_valid), 32'hF);
        check("route_data",  32'(bus.out_data),  32'hC35A);
        check("route_count", 32'(bus.out_count), 32'h55);
        bus.out_ready = 4'b1111;
        tick();
        bus.out_ready = 4'b0000;
        check("route_drained", 32'(bus.out_valid), 32'h0);

        // 3. full / backpressure on output 2
        bus.in_sel = 2'd2;
        for (int i = 1; i <= 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 4'(i);
            tick();
        end
        check("bp_count2", 32'(bus.out_count), 32'h20);
        bus.in_data = 4'h3;
        settle();
        check("bp_ready_full", 32'(bus.in_ready), 32'h0);
        tick();
        check("bp_held_count", 32'(bus.out_count), 32'h20);
        check("bp_head_stable", 32'(bus.out_data[11:8]), 32'h1);
        bus.out_ready = 4'b0100;
        settle();
        check("bp_ready_pop", 32'(bus.in_ready), 32'h1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_order2", 32'(bus.out_data[11:8]), 32'h2);
        check("bp_count_after", 32'(bus.out_count), 32'h20);
        tick();
        check("bp_order3", 32'(bus.out_data[11:8]), 32'h3);
        tick();
        check("bp_empty", 32'(bus.out_valid), 32'h0);
        bus.out_ready = 4'b0000;

        // 4. isolation: FIFO 0 full and stalled
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd0;
        bus.in_data  = 4'h7;
        tick();
        bus.in_data  = 4'h8;
        tick();
        settle();
        check("iso_full0_ready", 32'(bus.in_ready), 32'h0);
        bus.out_ready = 4'b0010;
        bus.in_sel    = 2'd1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = 4'(9 + i);
            settle();
            check("iso_ready1", 32'(bus.in_ready), 32'h1);
            tick();
            check("iso_data1", 32'(bus.out_data[7:4]), 32'(9 + i));
        end
        bus.in_valid = 1'b0;
        tick();
        check("iso_valid", 32'(bus.out_valid), 32'h1);
        check("iso_count", 32'(bus.out_count), 32'h02);
        bus.out_ready = 4'b0001;
        settle();
        check("iso_head0_a", 32'(bus.out_data[3:0]), 32'h7);
        tick();
        check("iso_head0_b", 32'(bus.out_data[3:0]), 32'h8);
        tick();
        check("iso_empty", 32'(bus.out_valid), 32'h0);

        // 5. wrap-around through FIFO 3
        bus.out_ready = 4'b1000;
        bus.in_sel    = 2'd3;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = 4'(i);
            tick();
            check("wrap_data",  32'(bus.out_data[15:12]), 32'(i));
            check("wrap_count", 32'(bus.out_count),       32'h40);
        end
        bus.in_valid = 1'b0;
        tick();
        check("wrap_drained", 32'(bus.out_count), 32'h0);
        bus.out_ready = 4'b0000;

        // 6. async reset mid-stream
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd0;
        bus.in_data  = 4'h4;
        tick();
        bus.in_data  = 4'h5;
        tick();
        bus.in_sel   = 2'd1;
        bus.in_data  = 4'hE;
        tick();
        bus.in_valid = 1'b0;
        check("ar_before", 32'(bus.out_valid), 32'h3);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(bus.out_valid), 32'h0);
        check("ar_count", 32'(bus.out_count), 32'h0);
        check("ar_data",  32'(bus.out_data),  32'h0);
        #4;
        rst_n = 1'b1;
        tick();
        check("ar_post_valid", 32'(bus.out_valid), 32'h0);
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd0;
        bus.in_data  = 4'h6;
        tick();
        bus.in_valid = 1'b0;
        check("ar_new_data",  32'(bus.out_data[3:0]), 32'h6);
        check("ar_new_count", 32'(bus.out_count),     32'h01);
        check("ar_new_valid", 32'(bus.out_valid),     32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
